job_scheduler: RTL and testbench
================================

JOB_SCHEDULER -- requirements
Module: job_scheduler

Interface
REQ-001 Parameter NCORES, default 4, sets the number of hash cores served (2..8).
REQ-002 Parameter BATCH_LOG2, default 16, sets the nonces per batch as 2^BATCH_LOG2.
REQ-003 clk  in  1  clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 job_load  in  1  single-cycle pulse: new 80-byte header received; start a job at nonce_base.
REQ-006 job_abort  in  1  level: header reception in progress; stop all dispatch.
REQ-007 nonce_base  in  32  first nonce of the job, sampled when job_load=1.
REQ-008 core_idle  in  NCORES  core i is ready for a batch.
REQ-009 core_found  in  NCORES  core i holds a result, held high until acknowledged.
REQ-010 core_result  in  32*NCORES  result nonce of core i in bits [32i+31:32i].
REQ-011 core_start  out  NCORES  one-hot, single-cycle pulse: core i begins a batch.
REQ-012 core_nonce  out  32  first nonce of the batch, valid when any core_start bit is set.
REQ-013 res_ack  out  NCORES  one-hot, single-cycle pulse: result of core i consumed.
REQ-014 res_wr  out  1  single-cycle pulse: push res_data into the output FIFO.
REQ-015 res_data  out  32  result nonce written to the FIFO.
REQ-016 res_full  in  1  output FIFO full.
REQ-017 busy  out  1  high when the FSM is not in IDLE.
REQ-018 exhausted  out  1  sticky flag: the 32-bit nonce space has been fully issued.

Function
REQ-019 All outputs are registered; the FSM has three states: IDLE, DISPATCH, DRAIN.
REQ-020 IDLE + job_load=1 -> next_nonce<=nonce_base; exhausted<=0; go to DISPATCH.
REQ-021 DISPATCH issues at most one start per cycle to the lowest-index eligible core.
- Eligible: core_idle[i]=1 and core i was not started in the previous cycle.
REQ-022 Each start: core_start[i]=1 for one cycle; core_nonce=next_nonce; next_nonce+=2^BATCH_LOG2 mod 2^32.
REQ-023 Carry-out of that add: exhausted<=1 and DISPATCH->DRAIN; no further starts are issued.
REQ-024 DRAIN->IDLE when all core_idle=1 and core_found=0 for one full cycle.
REQ-025 job_load in DISPATCH or DRAIN reloads next_nonce from nonce_base, clears exhausted, and goes to DISPATCH.
REQ-026 job_abort=1 in any state: no starts issued; next state is IDLE; exhausted<=0.
- While job_abort=1, no state other than IDLE is entered.
REQ-027 job_load and job_abort high in the same cycle: job_abort wins.
REQ-028 The result arbiter runs in every state and is independent of the FSM.
- Round-robin over core_found; the search begins at ptr; ptr<=grant+1 mod NCORES after each grant.
REQ-029 A grant of core g: next cycle res_ack[g]=1, res_wr=1, res_data=core_result[g].
- Maximum of one grant per cycle.
REQ-030 No grant is made when res_full=1 in the decision cycle; pending results wait and none are lost.
REQ-031 A core granted in cycle t is excluded from arbitration in cycle t+1, so a held core_found is never double-counted.
REQ-032 While job_abort=1, grants proceed with res_ack pulsed and res_wr held 0: stale results are flushed.
REQ-033 Latency: job_load to the first core_start is 2 cycles; core_found to res_wr is 1 cycle.

Reset
REQ-034 rst=1 asynchronously forces the following state:
- FSM: IDLE.
- Outputs: core_start=0, res_ack=0, res_wr=0, res_data=0, core_nonce=0, busy=0, exhausted=0.
- Internal: ptr=0, next_nonce=0.
REQ-035 rst asserted mid-job drops all in-flight dispatch and arbitration state; no pulse is emitted on the cycle rst deasserts.

Verification
REQ-036 rst; job_load with nonce_base=0x00001000; all cores idle -> core_start pulses 0001, 0010, 0100, 1000 on consecutive cycles; core_nonce=0x1000, 0x11000, 0x21000, 0x31000.
REQ-037 nonce_base=0xFFFE0000, BATCH_LOG2=16 -> two starts (0xFFFE0000, 0xFFFF0000); exhausted=1; DRAIN; IDLE once cores are idle; busy=0.
REQ-038 core_found=1111 held until ack, res_full=0 -> res_data order core0..core3 on 4 consecutive cycles; each res_ack once; no duplicates.
REQ-039 res_full=1 for 5 cycles with core_found[2]=1 -> res_wr=0 throughout; single res_wr with core2's result 1 cycle after res_full falls.
REQ-040 job_abort mid-DISPATCH with core_found[1]=1 -> no core_start; res_ack[1] pulses with res_wr=0; IDLE; exhausted=0.
REQ-041 Same-cycle job_load+job_abort -> state stays IDLE; rst mid-DISPATCH -> all outputs 0 immediately.

Source files
------------

// File: rtl/job_scheduler.sv
// Hands out nonce batches to NCORES hash cores, one start per cycle, and
// funnels their results into the output FIFO through a round-robin arbiter.
module job_scheduler #(
   parameter int NCORES     = 4,
   parameter int BATCH_LOG2 = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_load,
   input  logic                 job_abort,
   input  logic [31:0]          nonce_base,
   input  logic [NCORES-1:0]    core_idle,
   input  logic [NCORES-1:0]    core_found,
   input  logic [32*NCORES-1:0] core_result,
   output logic [NCORES-1:0]    core_start,
   output logic [31:0]          core_nonce,
   output logic [NCORES-1:0]    res_ack,
   output logic                 res_wr,
   output logic [31:0]          res_data,
   input  logic                 res_full,
   output logic                 busy,
   output logic                 exhausted
);

   localparam int          PW        = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam logic [32:0] BATCH_INC = 33'd1 << BATCH_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_next_s;
   logic [31:0]         next_nonce_r;
   logic [31:0]         nonce_next_s;
   logic                exh_next_s;
   logic [32:0]         batch_sum_s;
   logic [NCORES-1:0]   start_s;
   logic [NCORES-1:0]   disp_elig_s;
   logic [NCORES-1:0]   disp_onehot_s;
   logic                disp_hit_s;

   logic [PW-1:0]       ptr_r;
   logic [NCORES-1:0]   arb_req_s;
   logic [NCORES-1:0]   arb_onehot_s;
   logic [PW-1:0]       arb_idx_s;
   logic                arb_hit_s;
   logic                grant_s;

   logic [NCORES-1:0]   core_start_r;
   logic [31:0]         core_nonce_r;
   logic [NCORES-1:0]   res_ack_r;
   logic                res_wr_r;
   logic [31:0]         res_data_r;
   logic                busy_r;
   logic                exhausted_r;

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base,
                                              input int unsigned   off);
      int unsigned sum;
      sum = 32'(base) + off;
      sum = (sum >= unsigned'(NCORES)) ? (sum - unsigned'(NCORES)) : sum;
      return PW'(sum);
   endfunction

   assign batch_sum_s = {1'b0, next_nonce_r} + BATCH_INC;

   // Lowest-index idle core, skipping the one started last cycle (its idle is stale).
   always_comb begin
      disp_elig_s   = core_idle & ~core_start_r;
      disp_hit_s    = 1'b0;
      disp_onehot_s = '0;
      for (int k = NCORES - 1; k >= 0; k--) begin
         if (disp_elig_s[k]) begin
            disp_hit_s       = 1'b1;
            disp_onehot_s    = '0;
            disp_onehot_s[k] = 1'b1;
         end else begin
            disp_hit_s = disp_hit_s;
         end
      end
   end

   // Next-state and dispatch decisions; abort overrides load in every state.
   always_comb begin
      state_next_s = state_r;
      nonce_next_s = next_nonce_r;
      exh_next_s   = exhausted_r;
      start_s      = '0;
      if (job_abort) begin
         state_next_s = ST_IDLE;
         exh_next_s   = 1'b0;
      end else if (job_load) begin
         state_next_s = ST_DISPATCH;
         nonce_next_s = nonce_base;
         exh_next_s   = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_next_s = ST_IDLE;
            end
            ST_DISPATCH: begin
               if (disp_hit_s) begin
                  start_s      = disp_onehot_s;
                  nonce_next_s = batch_sum_s[31:0];
                  if (batch_sum_s[32]) begin
                     exh_next_s   = 1'b1;
                     state_next_s = ST_DRAIN;
                  end else begin
                     state_next_s = ST_DISPATCH;
                  end
               end else begin
                  state_next_s = ST_DISPATCH;
               end
            end
            ST_DRAIN: begin
               if ((&core_idle) && !(|core_found)) begin
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = ST_DRAIN;
               end
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state, nonce counter and dispatch-side outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         next_nonce_r <= 32'd0;
         exhausted_r  <= 1'b0;
         busy_r       <= 1'b0;
         core_start_r <= '0;
         core_nonce_r <= 32'd0;
      end else begin
         state_r      <= state_next_s;
         next_nonce_r <= nonce_next_s;
         exhausted_r  <= exh_next_s;
         busy_r       <= (state_next_s != ST_IDLE);
         core_start_r <= start_s;
         if (|start_s) begin
            core_nonce_r <= next_nonce_r;
         end
      end
   end

   // Round-robin search from ptr; a core acked last cycle still shows found, so mask it.
   always_comb begin
      arb_req_s = core_found & ~res_ack_r;
      arb_hit_s = 1'b0;
      arb_idx_s = '0;
      for (int k = NCORES - 1; k >= 0; k--) begin
         if (arb_req_s[wrap_idx(ptr_r, unsigned'(k))]) begin
            arb_hit_s = 1'b1;
            arb_idx_s = wrap_idx(ptr_r, unsigned'(k));
         end else begin
            arb_hit_s = arb_hit_s;
         end
      end
      grant_s      = arb_hit_s & ~res_full;
      arb_onehot_s = {{(NCORES-1){1'b0}}, 1'b1} << arb_idx_s;
   end

   // Result arbiter outputs; during abort results are acked but not written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r      <= '0;
         res_ack_r  <= '0;
         res_wr_r   <= 1'b0;
         res_data_r <= 32'd0;
      end else if (grant_s) begin
         ptr_r      <= wrap_idx(arb_idx_s, 32'd1);
         res_ack_r  <= arb_onehot_s;
         res_wr_r   <= ~job_abort;
         res_data_r <= core_result[32*arb_idx_s +: 32];
      end else begin
         res_ack_r  <= '0;
         res_wr_r   <= 1'b0;
      end
   end

   assign core_start = core_start_r;
   assign core_nonce = core_nonce_r;
   assign res_ack    = res_ack_r;
   assign res_wr     = res_wr_r;
   assign res_data   = res_data_r;
   assign busy       = busy_r;
   assign exhausted  = exhausted_r;

endmodule

// File: tb/tb_job_scheduler.sv
// Self-checking bench for job_scheduler: dispatch vectors from a table,
// result path checked through an expected-result queue.
module tb_job_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic         job_load;
   logic         job_abort;
   logic [31:0]  nonce_base;
   logic [3:0]   core_idle;
   logic [3:0]   core_found;
   logic [127:0] core_result;
   logic [3:0]   core_start;
   logic [31:0]  core_nonce;
   logic [3:0]   res_ack;
   logic         res_wr;
   logic [31:0]  res_data;
   logic         res_full;
   logic         busy;
   logic         exhausted;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic        load;
      logic        abort;
      logic [31:0] base;
      logic [3:0]  idle;
      logic [3:0]  exp_start;
      logic [31:0] exp_nonce;
      logic        exp_busy;
      logic        exp_exh;
   } vec_t;

   vec_t vecs [16];

   job_scheduler #(.NCORES(4), .BATCH_LOG2(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .job_load    (job_load),
      .job_abort   (job_abort),
      .nonce_base  (nonce_base),
      .core_idle   (core_idle),
      .core_found  (core_found),
      .core_result (core_result),
      .core_start  (core_start),
      .core_nonce  (core_nonce),
      .res_ack     (res_ack),
      .res_wr      (res_wr),
      .res_data    (res_data),
      .res_full    (res_full),
      .busy        (busy),
      .exhausted   (exhausted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every FIFO write must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && res_wr) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL res_wr_unexpected: got data %h expected no write", res_data);
         end else begin
            check("res_data", res_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [3:0] prev_ack;
      int         ack_cnt [4];

      // load abort base idle | start nonce busy exh
      vecs[0]  = '{1'b1, 1'b0, 32'h0000_1000, 4'hF, 4'h0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'h1, 32'h0000_1000, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0000_0000, 4'hE, 4'h2, 32'h0001_1000, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 4'hC, 4'h4, 32'h0002_1000, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h0000_0000, 4'h8, 4'h8, 32'h0003_1000, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 32'h0000_0000, 4'h1, 4'h1, 32'h0004_1000, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h0000_0000, 4'h0, 4'h0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'hFFFE_0000, 4'hF, 4'h0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'h1, 32'hFFFE_0000, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 32'h0000_0000, 4'hE, 4'h2, 32'hFFFF_0000, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 32'h0000_0000, 4'hC, 4'h0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'h0, 32'h0000_0000, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'h0, 32'h0000_0000, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 32'h0000_1234, 4'hF, 4'h0, 32'h0000_0000, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 32'h0000_0000, 4'hF, 4'h0, 32'h0000_0000, 1'b0, 1'b0};

      rst         = 1'b1;
      job_load    = 1'b0;
      job_abort   = 1'b0;
      nonce_base  = 32'h0;
      core_idle   = 4'hF;
      core_found  = 4'h0;
      core_result = 128'h0;
      res_full    = 1'b0;
      repeat (3) tick();
      check("reset core_start", 32'(core_start), 32'h0);
      check("reset core_nonce", core_nonce, 32'h0);
      check("reset res_ack", 32'(res_ack), 32'h0);
      check("reset res_wr", 32'(res_wr), 32'h0);
      check("reset res_data", res_data, 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset exhausted", 32'(exhausted), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         job_load   = vecs[i].load;
         job_abort  = vecs[i].abort;
         nonce_base = vecs[i].base;
         core_idle  = vecs[i].idle;
         tick();
         check($sformatf("v%0d core_start", i), 32'(core_start), 32'(vecs[i].exp_start));
         if (vecs[i].exp_start != 4'h0) begin
            check($sformatf("v%0d core_nonce", i), core_nonce, vecs[i].exp_nonce);
         end
         check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         check($sformatf("v%0d exhausted", i), 32'(exhausted), 32'(vecs[i].exp_exh));
      end
      job_load  = 1'b0;
      job_abort = 1'b0;

      // abort in the middle of dispatch while core1 holds a stale result
      core_idle  = 4'hF;
      job_load   = 1'b1;
      nonce_base = 32'h5000_0000;
      tick();
      job_load = 1'b0;
      tick();
      check("abort pre start", 32'(core_start), 32'h1);
      check("abort pre nonce", core_nonce, 32'h5000_0000);
      core_result[63:32] = 32'hCAFE_0001;
      job_abort  = 1'b1;
      core_idle  = 4'hE;
      core_found = 4'b0010;
      tick();
      check("abort core_start", 32'(core_start), 32'h0);
      check("abort res_ack", 32'(res_ack), 32'h2);
      check("abort res_wr", 32'(res_wr), 32'h0);
      check("abort busy", 32'(busy), 32'h0);
      check("abort exhausted", 32'(exhausted), 32'h0);
      tick();
      check("abort held found no reack", 32'(res_ack), 32'h0);
      check("abort held core_start", 32'(core_start), 32'h0);
      core_found = 4'h0;
      job_abort  = 1'b0;
      core_idle  = 4'hF;
      tick();
      check("after abort busy", 32'(busy), 32'h0);
      check("after abort core_start", 32'(core_start), 32'h0);

      // asynchronous reset in the middle of dispatch
      job_load   = 1'b1;
      nonce_base = 32'h7000_0000;
      tick();
      job_load = 1'b0;
      tick();
      check("rstseq pre start", 32'(core_start), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("rstseq core_start", 32'(core_start), 32'h0);
      check("rstseq core_nonce", core_nonce, 32'h0);
      check("rstseq busy", 32'(busy), 32'h0);
      check("rstseq exhausted", 32'(exhausted), 32'h0);
      check("rstseq res_ack", 32'(res_ack), 32'h0);
      check("rstseq res_wr", 32'(res_wr), 32'h0);
      check("rstseq res_data", res_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("rstseq release core_start", 32'(core_start), 32'h0);
      check("rstseq release busy", 32'(busy), 32'h0);
      check("rstseq release res_wr", 32'(res_wr), 32'h0);

      // all four cores report; cores drop found one cycle after seeing ack
      core_result = {32'hD0D0_0003, 32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(core_result[32*i +: 32]);
         ack_cnt[i] = 0;
      end
      core_found = 4'hF;
      prev_ack   = 4'h0;
      for (int c = 0; c < 6; c++) begin
         tick();
         check($sformatf("rr cycle%0d res_wr", c), 32'(res_wr), (c < 4) ? 32'd1 : 32'd0);
         for (int k = 0; k < 4; k++) begin
            if (res_ack[k]) ack_cnt[k]++;
         end
         core_found = core_found & ~prev_ack;
         prev_ack   = res_ack;
      end
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rr ack count core%0d", k), 32'(ack_cnt[k]), 32'd1);
      end
      check("rr queue drained", 32'(exp_q.size()), 32'd0);

      // FIFO full holds off a pending result without losing it
      core_result[95:64] = 32'hABCD_0002;
      exp_q.push_back(32'hABCD_0002);
      res_full   = 1'b1;
      core_found = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("full cycle%0d ack/wr", c), 32'({res_ack, res_wr}), 32'h0);
      end
      res_full = 1'b0;
      tick();
      check("full release res_wr", 32'(res_wr), 32'h1);
      check("full release res_ack", 32'(res_ack), 32'h4);
      tick();
      check("full held found no rewrite", 32'(res_wr), 32'h0);
      core_found = 4'h0;
      tick();
      check("full after res_wr", 32'(res_wr), 32'h0);
      check("full queue drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
